deshuffle_cmt_sched: RTL and testbench
======================================

DESHUFFLE_CMT_SCHED -- requirements
Module: deshuffle_cmt_sched

Interface
REQ-001 SHALL have parameter NrLanes, default 4, number of lanes feeding the shuffle buffer.
REQ-002 SHALL have parameter InfoDepth, default 4, meta-info queue depth; power of two, minimum 2.
REQ-003 SHALL have parameter CntWidth, default 8, width of the commit-beat count.
REQ-004 SHALL have parameter ReqIdWidth, default 4, width of the request id.
REQ-005 SHALL have ports, clock and reset first, one per line:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- meta_valid_i  in  1  meta-info offer.
- meta_ready_o  out  1  meta-info accept.
- meta_req_id_i  in  ReqIdWidth  request id.
- meta_cmt_cnt_i  in  CntWidth  number of beats minus one.
- meta_vm_i  in  1  1 = unmasked request.
- lane_full_i  in  NrLanes  per-lane shuffle-buffer entry valid.
- mask_valid_i  in  NrLanes  per-lane mask available.
- mask_ready_o  out  1  mask consumed.
- cmt_valid_o  out  1  deshuffled beat ready for the sequential store.
- cmt_ready_i  in  1  sequential store accepts the beat.
- cmt_req_id_o  out  ReqIdWidth  id of the committing request.
- cmt_vm_o  out  1  vm of the committing request.
- cmt_last_o  out  1  final beat of the request.
- shf_clr_o  out  1  clear all shuffle-buffer lanes.
- done_valid_o  out  1  one-cycle request-complete pulse.
- done_req_id_o  out  ReqIdWidth  id of the completed request.
- occupancy_o  out  clog2(InfoDepth)+1  number of queued entries.
- busy_o  out  1  block is not idle.
- err_o  out  1  sticky protocol error.

Function
REQ-006 SHALL hold meta entries {req_id, cmt_cnt, vm} in a FIFO with InfoDepth entries, using enq/deq pointers plus a wrap flag; empty = pointers and flags equal; full = pointers equal and flags differ.
REQ-007 SHALL drive meta_ready_o = !full; there is no bypass when full, even if a dequeue happens in the same cycle.
REQ-008 SHALL perform a same-cycle enqueue and dequeue together, leaving occupancy_o unchanged.
REQ-009 SHALL implement the FSM IDLE/LOAD/RUN with these transitions:
- IDLE -> LOAD when the queue is non-empty.
- LOAD: beat_cnt <= head.cmt_cnt, then -> RUN.
- RUN -> LOAD on a last-beat fire if entries remain after the dequeue.
- RUN -> IDLE on a last-beat fire if the queue becomes empty.
REQ-010 SHALL assert cmt_valid_o only in RUN, and only when &lane_full_i && (head.vm || &mask_valid_i); cmt_valid_o SHALL NOT depend on cmt_ready_i.
REQ-011 SHALL define fire = cmt_valid_o && cmt_ready_i; shf_clr_o = fire.
REQ-012 SHALL drive mask_ready_o = fire && !head.vm.
REQ-013 SHALL drive cmt_req_id_o/cmt_vm_o from the queue head, and cmt_last_o = (beat_cnt == 0); cmt_req_id_o, cmt_vm_o and cmt_last_o are only meaningful while cmt_valid_o is high.
REQ-014 SHALL decrement beat_cnt by 1 on a non-last fire; on a last fire it SHALL dequeue the head with no decrement, so beat_cnt never underflows.
REQ-015 SHALL register done_valid_o high for exactly one cycle, the cycle after a last-beat fire, with done_req_id_o set to the id of the completed entry.
REQ-016 SHALL have a minimum latency from meta acceptance (cycle 0) to the earliest cmt_valid_o of cycle 2, and one bubble cycle (LOAD) between back-to-back requests.
REQ-017 SHALL drive busy_o = (state != IDLE) || !empty.
REQ-018 SHALL set err_o, sticky until reset, when &lane_full_i occurs while the queue is empty, or when mask_valid_i changes while cmt_valid_o is high and cmt_ready_i is low.
REQ-019 SHALL handle pointer wrap-around without loss, and flip each wrap flag when its pointer passes InfoDepth-1.

Reset
REQ-020 SHALL, while rst_i is high at a clock edge, set state IDLE, both pointers and flags 0, beat_cnt 0, err_o 0 and done_valid_o 0.
REQ-021 SHALL, during reset, drive meta_ready_o 0 and cmt_valid_o, mask_ready_o and shf_clr_o 0; occupancy_o SHALL read 0 after reset.
REQ-022 SHALL discard all queued entries when reset is asserted mid-request; no done pulse is issued for the discarded entries.

Verification
REQ-023 SHALL cover: one meta {id=3, cnt=2, vm=1}, lanes full, ready held high -> three fires on cycles 2, 3, 4, cmt_last_o on the third, done_valid_o with id 3 on cycle 5.
REQ-024 SHALL cover: vm=0 with mask_valid_i all ones except one lane -> no fire; set the last lane -> fire, with mask_ready_o = 1 in the same cycle.
REQ-025 SHALL cover: enqueue 4 entries with InfoDepth=4 -> meta_ready_o=0 and occupancy_o=4; after the first last-beat fire, meta_ready_o returns to 1 on the next cycle.
REQ-026 SHALL cover: 9 requests streamed through InfoDepth=4 -> completion order and ids are preserved across pointer wrap.
REQ-027 SHALL cover: lane_full_i all ones with an empty queue -> err_o=1 and it stays 1 until rst_i.
REQ-028 SHALL cover: rst_i asserted during the second beat of cnt=3 -> next cycle state IDLE, occupancy_o=0, no done pulse.

Source files
------------

// File: rtl/deshuffle_cmt_sched.sv
// Commit scheduler for the deshuffle buffer: queues request meta-info, then emits one
// commit beat per full-lane cycle, clears the shuffle buffer on each beat and pulses done.
module deshuffle_cmt_sched #(
  parameter int NrLanes    = 4,
  parameter int InfoDepth  = 4,
  parameter int CntWidth   = 8,
  parameter int ReqIdWidth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         meta_valid_i,
  output logic                         meta_ready_o,
  input  logic [ReqIdWidth-1:0]        meta_req_id_i,
  input  logic [CntWidth-1:0]          meta_cmt_cnt_i,
  input  logic                         meta_vm_i,
  input  logic [NrLanes-1:0]           lane_full_i,
  input  logic [NrLanes-1:0]           mask_valid_i,
  output logic                         mask_ready_o,
  output logic                         cmt_valid_o,
  input  logic                         cmt_ready_i,
  output logic [ReqIdWidth-1:0]        cmt_req_id_o,
  output logic                         cmt_vm_o,
  output logic                         cmt_last_o,
  output logic                         shf_clr_o,
  output logic                         done_valid_o,
  output logic [ReqIdWidth-1:0]        done_req_id_o,
  output logic [$clog2(InfoDepth):0]   occupancy_o,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int PtrW = $clog2(InfoDepth);
  localparam int OccW = PtrW + 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                  state;
  logic [ReqIdWidth-1:0]   id_mem  [InfoDepth];
  logic [CntWidth-1:0]     cnt_mem [InfoDepth];
  logic                    vm_mem  [InfoDepth];
  logic [PtrW-1:0]         enq_ptr, deq_ptr;
  logic                    enq_wrap, deq_wrap;
  logic [CntWidth-1:0]     beat_cnt;
  logic [NrLanes-1:0]      mask_q;
  logic                    stall_q;

  logic                    empty, full, enq, deq, fire, last;
  logic [ReqIdWidth-1:0]   head_id;
  logic                    head_vm;
  logic [OccW-1:0]         occ_next;

  assign empty   = (enq_ptr == deq_ptr) && (enq_wrap == deq_wrap);
  assign full    = (enq_ptr == deq_ptr) && (enq_wrap != deq_wrap);
  assign head_id = id_mem[deq_ptr];
  assign head_vm = vm_mem[deq_ptr];

  // Outputs are forced low while reset is asserted, regardless of stale state.
  assign meta_ready_o = !full && !rst_i;
  assign cmt_valid_o  = !rst_i && (state == RUN) && (&lane_full_i) && (head_vm || (&mask_valid_i));
  assign fire         = cmt_valid_o && cmt_ready_i;
  assign last         = (beat_cnt == '0);
  assign shf_clr_o    = fire;
  assign mask_ready_o = fire && !head_vm;
  assign cmt_req_id_o = head_id;
  assign cmt_vm_o     = head_vm;
  assign cmt_last_o   = last;

  assign enq         = meta_valid_i && meta_ready_o;
  assign deq         = fire && last;
  assign occupancy_o = {enq_wrap, enq_ptr} - {deq_wrap, deq_ptr};
  assign occ_next    = occupancy_o + OccW'(enq) - OccW'(deq);
  assign busy_o      = (state != IDLE) || !empty;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      id_mem[enq_ptr]  <= meta_req_id_i;
      cnt_mem[enq_ptr] <= meta_cmt_cnt_i;
      vm_mem[enq_ptr]  <= meta_vm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      enq_ptr       <= '0;
      deq_ptr       <= '0;
      enq_wrap      <= 1'b0;
      deq_wrap      <= 1'b0;
      beat_cnt      <= '0;
      err_o         <= 1'b0;
      done_valid_o  <= 1'b0;
      done_req_id_o <= '0;
      mask_q        <= '0;
      stall_q       <= 1'b0;
    end else begin
      if (enq) begin
        if (enq_ptr == PtrW'(InfoDepth - 1)) begin
          enq_ptr  <= '0;
          enq_wrap <= !enq_wrap;
        end else begin
          enq_ptr <= enq_ptr + PtrW'(1);
        end
      end
      if (deq) begin
        if (deq_ptr == PtrW'(InfoDepth - 1)) begin
          deq_ptr  <= '0;
          deq_wrap <= !deq_wrap;
        end else begin
          deq_ptr <= deq_ptr + PtrW'(1);
        end
      end

      // Entering LOAD on the enqueue edge itself keeps the first beat at cycle 2.
      case (state)
        IDLE: if (!empty || enq) state <= LOAD;
        LOAD: begin
          beat_cnt <= cnt_mem[deq_ptr];
          state    <= RUN;
        end
        RUN: begin
          if (fire && !last) beat_cnt <= beat_cnt - CntWidth'(1);
          if (deq) state <= (occ_next != '0) ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase

      done_valid_o <= deq;
      if (deq) done_req_id_o <= head_id;

      mask_q  <= mask_valid_i;
      stall_q <= cmt_valid_o && !cmt_ready_i;
      if (((&lane_full_i) && empty) || (stall_q && (mask_valid_i != mask_q))) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_deshuffle_cmt_sched.sv
// Scenario bench for deshuffle_cmt_sched: per-beat and per-request scoreboards
// filled at meta acceptance, drained by a monitor as beats fire and done pulses appear.
module tb_deshuffle_cmt_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       meta_valid = 1'b0;
  logic       meta_ready;
  logic [3:0] meta_req_id = '0;
  logic [7:0] meta_cmt_cnt = '0;
  logic       meta_vm = 1'b0;
  logic [3:0] lane_full;
  logic [3:0] mask_valid = 4'hF;
  logic       mask_ready;
  logic       cmt_valid;
  logic       cmt_ready = 1'b0;
  logic [3:0] cmt_req_id;
  logic       cmt_vm;
  logic       cmt_last;
  logic       shf_clr;
  logic       done_valid;
  logic [3:0] done_req_id;
  logic [2:0] occupancy;
  logic       busy;
  logic       err;

  logic       force_full = 1'b0;
  logic       rnd_ready = 1'b0;

  typedef struct packed {
    logic [3:0] id;
    logic       vm;
    logic       last;
  } beat_t;

  beat_t      beat_q[$];
  logic [3:0] done_q[$];
  beat_t      mon_b;
  logic [3:0] mon_id;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  // Lanes look full whenever a request is queued; force_full models a stray fill.
  assign lane_full = (force_full || (occupancy != 3'd0)) ? 4'hF : 4'h0;

  deshuffle_cmt_sched dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .meta_valid_i  (meta_valid),
    .meta_ready_o  (meta_ready),
    .meta_req_id_i (meta_req_id),
    .meta_cmt_cnt_i(meta_cmt_cnt),
    .meta_vm_i     (meta_vm),
    .lane_full_i   (lane_full),
    .mask_valid_i  (mask_valid),
    .mask_ready_o  (mask_ready),
    .cmt_valid_o   (cmt_valid),
    .cmt_ready_i   (cmt_ready),
    .cmt_req_id_o  (cmt_req_id),
    .cmt_vm_o      (cmt_vm),
    .cmt_last_o    (cmt_last),
    .shf_clr_o     (shf_clr),
    .done_valid_o  (done_valid),
    .done_req_id_o (done_req_id),
    .occupancy_o   (occupancy),
    .busy_o        (busy),
    .err_o         (err)
  );

  always @(negedge clk) begin
    #2;
    if (cmt_valid && cmt_ready) begin
      total++;
      if (beat_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got id=%0d, expected no beat", cmt_req_id);
      end else begin
        mon_b = beat_q.pop_front();
        if ({cmt_req_id, cmt_vm, cmt_last, mask_ready, shf_clr} !== {mon_b.id, mon_b.vm, mon_b.last, ~mon_b.vm, 1'b1}) begin
          bad++;
          $display("FAIL beat: got id=%0d vm=%0b last=%0b mrdy=%0b clr=%0b, expected id=%0d vm=%0b last=%0b mrdy=%0b clr=1",
                   cmt_req_id, cmt_vm, cmt_last, mask_ready, shf_clr, mon_b.id, mon_b.vm, mon_b.last, ~mon_b.vm);
        end
      end
    end
    if (done_valid) begin
      total++;
      done_cnt++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got id=%0d, expected no done", done_req_id);
      end else begin
        mon_id = done_q.pop_front();
        if (done_req_id !== mon_id) begin
          bad++;
          $display("FAIL done_id: got %0d, expected %0d", done_req_id, mon_id);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    meta_valid = 1'b0;
    if (rnd_ready) cmt_ready = 1'($urandom_range(0, 1));
    #1;
  endtask

  task automatic send(input logic [3:0] id, input logic [7:0] cnt, input logic vm);
    int    w = 0;
    beat_t nb;
    @(negedge clk);
    meta_valid = 1'b1; meta_req_id = id; meta_cmt_cnt = cnt; meta_vm = vm;
    if (rnd_ready) cmt_ready = 1'($urandom_range(0, 1));
    #1;
    while (!meta_ready && w < 200) begin
      @(negedge clk);
      if (rnd_ready) cmt_ready = 1'($urandom_range(0, 1));
      #1;
      w++;
    end
    total++;
    if (!meta_ready) begin
      bad++;
      $display("FAIL send_accept: meta_ready=0 after %0d cycles, expected 1", w);
    end else begin
      for (int b = 0; b <= int'(cnt); b++) begin
        nb.id = id; nb.vm = vm; nb.last = (b == int'(cnt));
        beat_q.push_back(nb);
      end
      done_q.push_back(id);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || beat_q.size() != 0 || done_q.size() != 0) && n < 500) begin
      cyc();
      n++;
    end
    total++;
    if (busy || beat_q.size() != 0 || done_q.size() != 0) begin
      bad++;
      $display("FAIL drain: busy=%0b beats_left=%0d dones_left=%0d, expected 0 0 0", busy, beat_q.size(), done_q.size());
    end
    rnd_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; meta_valid = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    beat_q.delete();
    done_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if ({meta_ready, cmt_valid, mask_ready, shf_clr} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got rdy/vld/mrdy/clr=%b, expected 0000", {meta_ready, cmt_valid, mask_ready, shf_clr});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({occupancy, busy, err, done_valid, meta_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: got occ=%0d busy=%0b err=%0b done=%0b rdy=%0b, expected 0 0 0 0 1",
               occupancy, busy, err, done_valid, meta_ready);
    end
  endtask

  task automatic test_basic();
    cmt_ready = 1'b1;
    send(4'd3, 8'd2, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      total++;
      if (cmt_valid !== (k >= 2 && k <= 4)) begin
        bad++;
        $display("FAIL basic_valid c%0d: got %0b, expected %0b", k, cmt_valid, (k >= 2 && k <= 4));
      end
      if (k >= 2 && k <= 4) begin
        total++;
        if (cmt_last !== (k == 4)) begin
          bad++;
          $display("FAIL basic_last c%0d: got %0b, expected %0b", k, cmt_last, (k == 4));
        end
      end
      total++;
      if (done_valid !== (k == 5) || (k == 5 && done_req_id !== 4'd3)) begin
        bad++;
        $display("FAIL basic_done c%0d: got vld=%0b id=%0d, expected vld=%0b id=3", k, done_valid, done_req_id, (k == 5));
      end
    end
    drain();
  endtask

  task automatic test_mask();
    cmt_ready = 1'b1;
    mask_valid = 4'b0111;
    send(4'd5, 8'd0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      total++;
      if ({cmt_valid, mask_ready, busy} !== 3'b001) begin
        bad++;
        $display("FAIL mask_partial c%0d: got vld/mrdy/busy=%b, expected 001", k, {cmt_valid, mask_ready, busy});
      end
    end
    @(negedge clk);
    meta_valid = 1'b0;
    mask_valid = 4'hF;
    #1;
    total++;
    if ({cmt_valid, mask_ready, shf_clr, cmt_last} !== 4'b1111) begin
      bad++;
      $display("FAIL mask_full: got vld/mrdy/clr/last=%b, expected 1111", {cmt_valid, mask_ready, shf_clr, cmt_last});
    end
    drain();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL mask_err: got %0b, expected 0", err);
    end
  endtask

  task automatic test_full();
    cmt_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(4'(i), 8'd0, 1'b1);
    cyc();
    total++;
    if ({meta_ready, occupancy, cmt_valid} !== {1'b0, 3'd4, 1'b1}) begin
      bad++;
      $display("FAIL full_state: got rdy=%0b occ=%0d vld=%0b, expected 0 4 1", meta_ready, occupancy, cmt_valid);
    end
    @(negedge clk);
    cmt_ready = 1'b1;
    #1;
    total++;
    if ({cmt_valid, cmt_last, meta_ready} !== 3'b110) begin
      bad++;
      $display("FAIL full_fire: got vld/last/rdy=%b, expected 110", {cmt_valid, cmt_last, meta_ready});
    end
    cyc();
    total++;
    if ({meta_ready, occupancy} !== {1'b1, 3'd3}) begin
      bad++;
      $display("FAIL full_release: got rdy=%0b occ=%0d, expected 1 3", meta_ready, occupancy);
    end
    drain();
  endtask

  task automatic test_wrap();
    int start = done_cnt;
    rnd_ready = 1'b1;
    for (int i = 0; i < 9; i++)
      send(4'((i * 5 + 2) % 16), 8'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    rnd_ready = 1'b1;
    drain();
    total++;
    if (done_cnt - start !== 9) begin
      bad++;
      $display("FAIL wrap_count: got %0d dones, expected 9", done_cnt - start);
    end
  endtask

  task automatic test_err();
    force_full = 1'b1;
    cyc();
    cyc();
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set: got %0b, expected 1", err);
    end
    force_full = 1'b0;
    repeat (3) cyc();
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: got %0b, expected 1", err);
    end
    do_reset();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: got %0b, expected 0", err);
    end
  endtask

  task automatic test_rst_mid();
    cmt_ready = 1'b1;
    send(4'd9, 8'd3, 1'b1);
    cyc();
    cyc();
    total++;
    if ({cmt_valid, cmt_last} !== 2'b10) begin
      bad++;
      $display("FAIL rstmid_beat1: got vld/last=%b, expected 10", {cmt_valid, cmt_last});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({cmt_valid, meta_ready, shf_clr} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_gate: got vld/rdy/clr=%b, expected 000", {cmt_valid, meta_ready, shf_clr});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    beat_q.delete();
    done_q.delete();
    total++;
    if ({busy, occupancy, done_valid} !== {1'b0, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_state: got busy=%0b occ=%0d done=%0b, expected 0 0 0", busy, occupancy, done_valid);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      total++;
      if (done_valid !== 1'b0 || cmt_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_quiet c%0d: got done=%0b vld=%0b, expected 0 0", k, done_valid, cmt_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_full();
    test_wrap();
    test_err();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
